// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: beat kinds, opcode constants, FSM states and the word encoder
package instr_encoder_pkg;

    typedef enum logic [3:0] {
        K_R    = 4'd0,
        K_ADDI = 4'd1,
        K_J    = 4'd2,
        K_JAL  = 4'd3,
        K_LW   = 4'd4,
        K_SW   = 4'd5,
        K_BEQ  = 4'd6,
        K_BNE  = 4'd7,
        K_LUI  = 4'd8
    } kind_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_e;

    function automatic logic kind_legal(input logic [3:0] kind);
        return kind <= 4'd8;
    endfunction

    // Illegal kinds fall through to an all-zero word.
    function automatic logic [31:0] encode(
        input logic [3:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [4:0]  shamt,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] w;
        w = 32'h0;
        case (kind_e'(kind))
            K_R:     w = {OP_R, rs, rt, rd, shamt, funct};
            K_ADDI:  w = {OP_ADDI, rs, rt, imm};
            K_J:     w = {OP_J, target};
            K_JAL:   w = {OP_JAL, target};
            K_LW:    w = {OP_LW, rs, rt, imm};
            K_SW:    w = {OP_SW, rs, rt, imm};
            K_BEQ:   w = {OP_BEQ, rs, rt, imm};
            K_BNE:   w = {OP_BNE, rs, rt, imm};
            K_LUI:   w = {OP_LUI, 5'd0, rt, imm};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// enc_fifo: synchronous FIFO buffering encoded words (DEPTH power of two)
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;

    assign full  = cnt_q == FULL_CNT;
    assign empty = cnt_q == '0;
    assign rdata = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
        if (push) mem_d[wr_ptr_q] = wdata;
    end

    // Pointers flush on reset; storage contents need no reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Word storage
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes field beats into MIPS words and streams them to instruction memory
// Optional ENC_CHECK_EN: drop illegal-kind beats and raise a sticky err flag.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [5:0]  in_funct,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    input  logic        in_last,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    input  logic        imem_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] count,
    output logic        err
);
    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [15:0] count_q, count_d;
    logic        accept, push, pop, wr_fire, fifo_full, fifo_empty;
    logic [31:0] enc_word, fifo_rdata;

    assign in_ready   = state_q == S_LOAD && !fifo_full;
    assign accept     = in_valid && in_ready;
    assign enc_word   = encode(in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target);
    assign wr_fire    = we_q && imem_ready;
    assign pop        = !fifo_empty && (!we_q || imem_ready);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = state_q != S_IDLE;
    assign done       = state_q == S_DONE;
    assign count      = count_q;

`ifdef ENC_CHECK_EN
    logic err_q, err_d;
    assign push = accept && kind_legal(in_kind);
    assign err  = err_q;
    // Sticky illegal-kind flag, cleared by a honoured start
    always_comb begin
        err_d = (state_q == S_IDLE && start) ? 1'b0 : err_q | (accept && !kind_legal(in_kind));
    end
    // Error flag register
    always_ff @(posedge clk) begin
        err_q <= !rst_n ? 1'b0 : err_d;
    end
`else
    assign push = accept;
    assign err  = 1'b0;
`endif

    enc_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(32)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .wdata(enc_word),
        .rdata(fifo_rdata),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Write port refill and FSM next state; a pop reloads the output register in the same cycle it drains
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        count_d = count_q;
        if (wr_fire) begin
            addr_d  = addr_q + 32'd4;
            count_d = count_q + 16'd1;
            we_d    = 1'b0;
        end
        if (pop) begin
            we_d    = 1'b1;
            wdata_d = fifo_rdata;
        end
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_LOAD;
                addr_d  = base_addr;
                count_d = 16'd0;
            end
            S_LOAD:  state_d = (accept && in_last) ? S_DRAIN : S_LOAD;
            S_DRAIN: state_d = (fifo_empty && !we_q) ? S_DONE : S_DRAIN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, address, write-port and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            count_q <= 16'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder (honours ENC_CHECK_EN)
module tb_instr_encoder;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, in_ready, in_last;
    logic [31:0] base_addr;
    logic [3:0]  in_kind;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        imem_we, imem_ready, busy, done, err;
    logic [31:0] imem_addr, imem_wdata;
    logic [15:0] count;

    int          total = 0;
    int          bad = 0;
    int          n_acc = 0;
    logic [31:0] exp_addr = 32'h0;
    logic [63:0] sb [$];
    logic [63:0] sb_e;
    logic        st_prev = 1'b0;
    logic [31:0] st_addr, st_data;

    instr_encoder #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .imem_ready(imem_ready), .busy(busy), .done(done), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] k, input logic [4:0] rs, rt, rd, sh,
                                          input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tg);
        case (k)
            4'd0: return {6'd0, rs, rt, rd, sh, fn};
            4'd1: return {6'd8, rs, rt, imm};
            4'd2: return {6'd2, tg};
            4'd3: return {6'd3, tg};
            4'd4: return {6'd35, rs, rt, imm};
            4'd5: return {6'd43, rs, rt, imm};
            4'd6: return {6'd4, rs, rt, imm};
            4'd7: return {6'd5, rs, rt, imm};
            4'd8: return {6'd15, 5'd0, rt, imm};
            default: return 32'h0;
        endcase
    endfunction

    // Write monitor: pops the scoreboard on each accepted write, checks stall stability
    always @(negedge clk) begin
        if (!rst_n) begin
            st_prev <= 1'b0;
        end else if (imem_we) begin
            if (st_prev) begin
                chk("hold_addr", imem_addr, st_addr);
                chk("hold_data", imem_wdata, st_data);
            end
            if (imem_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_wr", 32'd1, 32'd0);
                end else begin
                    sb_e = sb.pop_front();
                    chk("wr_addr", imem_addr, sb_e[63:32]);
                    chk("wr_data", imem_wdata, sb_e[31:0]);
                end
                st_prev <= 1'b0;
            end else begin
                st_prev <= 1'b1;
                st_addr <= imem_addr;
                st_data <= imem_wdata;
            end
        end else begin
            if (st_prev) chk("held_we", 32'd0, 32'd1);
            st_prev <= 1'b0;
        end
    end

    task automatic do_start(input logic [31:0] b);
        start = 1'b1;
        base_addr = b;
        @(posedge clk);
        #1 start = 1'b0;
        exp_addr = b;
        @(negedge clk);
        chk("busy_load", busy, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] k, input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn,
                        input logic [15:0] imm, input logic [25:0] tg, input logic last,
                        input logic [31:0] exp_w, input bit wr);
        bit ok = 1'b0;
        in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh;
        in_funct = fn; in_imm = imm; in_target = tg; in_last = last; in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
        end
        if (!ok) @(posedge clk);
        #1 in_valid = 1'b0;
        in_last = 1'b0;
        chk("beat_accepted", 32'(ok), 32'd1);
        if (ok) begin
            n_acc++;
            if (wr) begin
                sb.push_back({exp_addr, exp_w});
                exp_addr += 32'd4;
            end
        end
    endtask

    task automatic rnd_beat(input logic last);
        logic [3:0] k;
        logic [4:0] rs, rt, rd, sh;
        logic [5:0] fn;
        logic [15:0] imm;
        logic [25:0] tg;
        k = 4'($urandom_range(0, 8));
        rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
        fn = 6'($urandom); imm = 16'($urandom); tg = 26'($urandom);
        send(k, rs, rt, rd, sh, fn, imm, tg, last, model(k, rs, rt, rd, sh, fn, imm, tg), 1'b1);
    endtask

    task automatic wait_done(input logic [15:0] exp_cnt);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("count", 32'(count), 32'(exp_cnt));
        chk("sb_empty", sb.size(), 32'd0);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("busy_idle", busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outs();
        chk("rst_we", imem_we, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_err", err, 0);
        chk("rst_in_ready", in_ready, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = 32'h0; in_valid = 1'b0; in_last = 1'b0;
        in_kind = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0;
        in_funct = 6'd0; in_imm = 16'd0; in_target = 26'd0; imem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outs();
        @(posedge clk);
        #1;

        // in_valid while IDLE is ignored
        in_valid = 1'b1; in_kind = 4'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;

        // single ADDI with first-write latency
        do_start(32'h0040_0000);
        send(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1, 32'h2008_0005, 1'b1);
        @(negedge clk);
        chk("lat_k", imem_we, 0);
        @(negedge clk);
        chk("lat_k1", imem_we, 1);
        wait_done(16'd1);

        // R then J, with an ignored start mid-load
        do_start(32'h0040_0000);
        send(4'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0, 32'h012A_4020, 1'b1);
        start = 1'b1; base_addr = 32'h0000_1234;
        @(posedge clk);
        #1 start = 1'b0;
        send(4'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h010_0000, 1'b1, 32'h0810_0000, 1'b1);
        wait_done(16'd2);

        // back-pressure: memory stalls while streaming
        imem_ready = 1'b0;
        do_start(32'h1000_0000);
        n_acc = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) rnd_beat(i == 7);
            end
            begin
                repeat (12) @(negedge clk);
                chk("stall_accepts", n_acc, FIFO_DEPTH + 1);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_count", 32'(count), 0);
                @(posedge clk);
                #1 imem_ready = 1'b1;
            end
        join
        wait_done(16'd8);

        // address wrap at top of memory
        do_start(32'hFFFF_FFFC);
        send(4'd8, 5'd7, 5'd3, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0, 32'h3C03_1234, 1'b1);
        send(4'd6, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0, 1'b1, 32'h1022_FFFF, 1'b1);
        wait_done(16'd2);

        // illegal kind handling
`ifdef ENC_CHECK_EN
        do_start(32'h0000_0100);
        send(4'd12, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'h6, 26'h7, 1'b1, 32'h0, 1'b0);
        wait_done(16'd0);
        chk("err_set", err, 1);
        do_start(32'h0000_0100);
        chk("err_cleared", err, 0);
        send(4'd4, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0, 1'b1, 32'h8FA8_0010, 1'b1);
        wait_done(16'd1);
`else
        do_start(32'h0000_0100);
        send(4'd12, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'h6, 26'h7, 1'b1, 32'h0, 1'b1);
        wait_done(16'd1);
        chk("err_tied", err, 0);
`endif

        // reset mid-load with words buffered
        imem_ready = 1'b0;
        do_start(32'h0000_2000);
        for (int i = 0; i < 4; i++) rnd_beat(1'b0);
        @(negedge clk);
        chk("pre_rst_we", imem_we, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        imem_ready = 1'b1;
        @(negedge clk);
        chk_reset_outs();
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_wr", imem_we, 0);
        end
        @(posedge clk);
        #1;
        do_start(32'h0040_0000);
        send(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1, 32'h2008_0005, 1'b1);
        wait_done(16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
